// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encoding and byte-enable constants for the memory arbiter.
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, IF_ACC, D_ACC, DONE} arb_state_t;
  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-enable and write-data lane steering for word or byte accesses.
module mem_lane_align
  import mem_arbiter_pkg::*;
(
  input  logic        i_byte,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata
);
  assign o_be = i_byte ? (4'b0001 << i_addr) : BE_WORD;
  assign o_wdata = i_byte ? {4{i_wdata[7:0]}} : i_wdata;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates an instruction-fetch and a data requester onto one Avalon-MM master,
// with alternating tie-break, misalignment errors and an optional waitrequest timeout.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_byte,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy
);
  arb_state_t  r_state, w_next;
  logic        r_last_d, r_sel_d, r_d_err, r_read, r_write;
  logic [31:0] r_if_rdata, r_d_rdata, r_address, r_writedata, r_wait_cnt;
  logic [3:0]  r_be, w_be;
  logic [31:0] w_wdata;
  logic        w_acc, w_ack, w_abort, w_grant_d, w_grant_if, w_mis;

  mem_lane_align u_lane (
    .i_byte  (d_byte),
    .i_addr  (d_addr[1:0]),
    .i_wdata (d_wdata),
    .o_be    (w_be),
    .o_wdata (w_wdata)
  );

  assign w_acc = (r_state == IF_ACC) || (r_state == D_ACC);
  assign w_ack = w_acc && !avm_waitrequest;
  assign w_abort = w_acc && avm_waitrequest && (WAIT_LIMIT != 0) && (r_wait_cnt == WAIT_LIMIT - 1);
  // r_last_d resets to 0 ("fetch served last"), so data wins the first tie
  assign w_grant_d = (r_state == IDLE) && d_req && (!if_req || !r_last_d);
  assign w_grant_if = (r_state == IDLE) && if_req && !w_grant_d;
  assign w_mis = !d_byte && (d_addr[1:0] != 2'b00);

  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = w_grant_d ? (w_mis ? DONE : D_ACC) : (w_grant_if ? IF_ACC : IDLE);
    else if (r_state == DONE) w_next = IDLE;
    else if (w_ack || w_abort) w_next = DONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_d <= 1'b0;
      r_sel_d <= 1'b0;
      r_d_err <= 1'b0;
      r_read <= 1'b0;
      r_write <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata <= '0;
      r_address <= '0;
      r_writedata <= '0;
      r_wait_cnt <= '0;
      r_be <= BE_NONE;
    end else begin
      r_wait_cnt <= (w_acc && avm_waitrequest) ? r_wait_cnt + 32'd1 : '0;
      if (w_grant_d) begin
        r_sel_d <= 1'b1;
        r_last_d <= 1'b1;
        r_d_err <= w_mis;
        r_address <= d_addr & ~32'h3;
        r_read <= !w_mis && !d_we;
        r_write <= !w_mis && d_we;
        r_be <= w_mis ? BE_NONE : w_be;
        r_writedata <= d_we ? w_wdata : '0;
      end else if (w_grant_if) begin
        r_sel_d <= 1'b0;
        r_last_d <= 1'b0;
        r_address <= if_addr & ~32'h3;
        r_read <= 1'b1;
        r_write <= 1'b0;
        r_be <= BE_WORD;
        r_writedata <= '0;
      end
      if (w_ack || w_abort) begin
        r_read <= 1'b0;
        r_write <= 1'b0;
      end
      if ((r_state == IF_ACC) && (w_ack || w_abort)) r_if_rdata <= w_ack ? avm_readdata : '0;
      if (r_state == D_ACC) begin
        r_d_err <= w_abort;
        if (w_ack && r_read) r_d_rdata <= avm_readdata;
      end
    end
  end

  assign busy = r_state != IDLE;
  assign if_done = (r_state == DONE) && !r_sel_d;
  assign d_done = (r_state == DONE) && r_sel_d;
  assign if_rdata = r_if_rdata;
  assign d_rdata = r_d_rdata;
  assign d_err = r_d_err;
  assign avm_address = r_address;
  assign avm_read = r_read;
  assign avm_write = r_write;
  assign avm_writedata = r_writedata;
  assign avm_byteenable = r_be;
endmodule
